// File: rtl/bar_plot_if.sv
// bar_plot_if: control plus SDRAM read/write handshake bundle for bar_plot_render.
interface bar_plot_if;
    logic        en;
    logic        iStart;
    logic        oBusy;
    logic        oDone;
    logic        oSDRAM_Rd_Req;
    logic [23:0] oSDRAM_Rd_Addr;
    logic [15:0] iSDRAM_Data;
    logic        iSDRAM_Rd_Done;
    logic        oSDRAM_Wr_Req;
    logic [23:0] oSDRAM_Wr_Addr;
    logic [15:0] oSDRAM_Wr_Data;
    logic        iSDRAM_Wr_Done;
    modport master (
        input  en, iStart, iSDRAM_Data, iSDRAM_Rd_Done, iSDRAM_Wr_Done,
        output oBusy, oDone, oSDRAM_Rd_Req, oSDRAM_Rd_Addr, oSDRAM_Wr_Req, oSDRAM_Wr_Addr, oSDRAM_Wr_Data
    );
    modport slave (
        output en, iStart, iSDRAM_Data, iSDRAM_Rd_Done, iSDRAM_Wr_Done,
        input  oBusy, oDone, oSDRAM_Rd_Req, oSDRAM_Rd_Addr, oSDRAM_Wr_Req, oSDRAM_Wr_Addr, oSDRAM_Wr_Data
    );
endinterface

// File: rtl/bar_plot_render.sv
// bar_plot_render: reads a photon-count history from SDRAM and redraws it as
// vertical bars into GRAM, column by column, top row first.
module bar_plot_render #(
    parameter int unsigned HIST_BASE   = 384000,
    parameter int unsigned HIST_LEN    = 600,
    parameter int unsigned X_OFS       = 100,
    parameter int unsigned LCD_W       = 800,
    parameter int unsigned LCD_H       = 480,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter logic [15:0] FG          = 16'hFFE0,
    parameter logic [15:0] BG          = 16'h0000
) (
    input logic        clk,
    input logic        rst_n,
    bar_plot_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, CALC, WR, NEXT_ROW, NEXT_COL, FIN} state_t;
    localparam logic [15:0] H_MAX = 16'(LCD_H - 1);
    localparam logic [15:0] C_MAX = 16'(HIST_LEN - 1);
    localparam logic [23:0] BASE  = 24'(HIST_BASE);
    localparam logic [23:0] PITCH = 24'(LCD_W);
    localparam logic [23:0] XO    = 24'(X_OFS);
    state_t      state_q, state_d;
    logic [15:0] c_q, c_d, r_q, r_d, h_q, h_d, sample_q, sample_d;
    logic [23:0] pa_q, pa_d;
    logic [15:0] scaled;
    always_comb begin
        scaled   = sample_q >> SCALE_SHIFT;
        state_d  = state_q;
        c_d      = c_q;
        r_d      = r_q;
        h_d      = h_q;
        sample_d = sample_q;
        pa_d     = pa_q;
        if (bus.en) begin
            case (state_q)
                IDLE: if (bus.iStart) begin
                    c_d     = '0;
                    state_d = RD;
                end
                RD: if (bus.iSDRAM_Rd_Done) begin
                    sample_d = bus.iSDRAM_Data;
                    state_d  = CALC;
                end
                CALC: begin
                    h_d     = scaled > H_MAX ? H_MAX : scaled;
                    r_d     = '0;
                    pa_d    = XO + {8'd0, c_q};
                    state_d = WR;
                end
                WR: state_d = bus.iSDRAM_Wr_Done ? NEXT_ROW : WR;
                // Pixel address advances by one GRAM row pitch instead of r*LCD_W.
                NEXT_ROW: if (r_q == H_MAX) state_d = NEXT_COL;
                else begin
                    r_d     = r_q + 16'd1;
                    pa_d    = pa_q + PITCH;
                    state_d = WR;
                end
                NEXT_COL: if (c_q == C_MAX) state_d = FIN;
                else begin
                    c_d     = c_q + 16'd1;
                    state_d = RD;
                end
                FIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            r_q      <= '0;
            h_q      <= '0;
            sample_q <= '0;
            pa_q     <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            r_q      <= r_d;
            h_q      <= h_d;
            sample_q <= sample_d;
            pa_q     <= pa_d;
        end
    end
    // Outputs decode straight from registered state so they are quiet while reset is held.
    assign bus.oBusy          = state_q != IDLE && state_q != FIN;
    assign bus.oDone          = state_q == FIN;
    assign bus.oSDRAM_Rd_Req  = state_q == RD;
    assign bus.oSDRAM_Rd_Addr = bus.oSDRAM_Rd_Req ? BASE + {8'd0, c_q} : '0;
    assign bus.oSDRAM_Wr_Req  = state_q == WR;
    assign bus.oSDRAM_Wr_Addr = pa_q;
    assign bus.oSDRAM_Wr_Data = bus.oSDRAM_Wr_Req ? (r_q > H_MAX - h_q ? FG : BG) : '0;
endmodule

// File: tb/tb_bar_plot_render.sv
// tb_bar_plot_render: directed redraw scenarios on a shrunken plot with an SDRAM/GRAM model.
module tb_bar_plot_render;
    localparam int HB = 1000, HL = 4, XO = 3, W = 16, H = 8, SS = 2;
    localparam logic [15:0] FG = 16'hFFE0, BG = 16'h0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0;
    logic [15:0] hist [HL];
    logic [15:0] gram [W*H];
    int rd_cnt, wr_cnt, done_cnt, proto_err, first_rd, first_wr, last_wr, rd_dly, wr_dly, ix;
    bit rand_en = 0, rd_armed = 0, wr_armed = 0;
    logic prev_rd = 0, prev_wr = 0;
    logic [23:0] prev_ra = 0, prev_wa = 0;
    logic [15:0] prev_wd = 0;

    bar_plot_if bus();
    bar_plot_render #(.HIST_BASE(HB), .HIST_LEN(HL), .X_OFS(XO), .LCD_W(W), .LCD_H(H),
                      .SCALE_SHIFT(SS), .FG(FG), .BG(BG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        bus.en = 1; bus.iSDRAM_Rd_Done = 0; bus.iSDRAM_Wr_Done = 0; bus.iSDRAM_Data = 0;
        forever begin
            @(negedge clk);
            if (bus.oSDRAM_Rd_Req && bus.oSDRAM_Wr_Req) proto_err++;
            if (prev_rd && bus.oSDRAM_Rd_Req && bus.oSDRAM_Rd_Addr != prev_ra) proto_err++;
            if (prev_wr && bus.oSDRAM_Wr_Req && (bus.oSDRAM_Wr_Addr != prev_wa || bus.oSDRAM_Wr_Data != prev_wd)) proto_err++;
            prev_rd = bus.oSDRAM_Rd_Req; prev_ra = bus.oSDRAM_Rd_Addr;
            prev_wr = bus.oSDRAM_Wr_Req; prev_wa = bus.oSDRAM_Wr_Addr; prev_wd = bus.oSDRAM_Wr_Data;
            if (!bus.oSDRAM_Rd_Req) begin bus.iSDRAM_Rd_Done = 0; rd_armed = 0; end
            else if (!bus.iSDRAM_Rd_Done) begin
                if (!rd_armed) begin rd_armed = 1; rd_dly = $urandom_range(0, 7); end
                if (rd_dly == 0) begin
                    ix = int'(bus.oSDRAM_Rd_Addr) - HB;
                    bus.iSDRAM_Data = (ix >= 0 && ix < HL) ? hist[ix] : 16'hBAD0;
                    bus.iSDRAM_Rd_Done = 1;
                end else rd_dly--;
            end
            if (!bus.oSDRAM_Wr_Req) begin bus.iSDRAM_Wr_Done = 0; wr_armed = 0; end
            else if (!bus.iSDRAM_Wr_Done) begin
                if (!wr_armed) begin wr_armed = 1; wr_dly = $urandom_range(0, 7); end
                if (wr_dly == 0) bus.iSDRAM_Wr_Done = 1; else wr_dly--;
            end
            bus.en = (!rand_en || !bus.oBusy) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.en && bus.oSDRAM_Rd_Req && bus.iSDRAM_Rd_Done) begin
                if (rd_cnt == 0) first_rd = int'(bus.oSDRAM_Rd_Addr);
                rd_cnt++;
            end
            if (bus.en && bus.oSDRAM_Wr_Req && bus.iSDRAM_Wr_Done) begin
                if (wr_cnt == 0) first_wr = int'(bus.oSDRAM_Wr_Addr);
                last_wr = int'(bus.oSDRAM_Wr_Addr);
                if (bus.oSDRAM_Wr_Addr < 24'(W*H)) gram[bus.oSDRAM_Wr_Addr] = bus.oSDRAM_Wr_Data;
                else proto_err++;
                wr_cnt++;
            end
            if (bus.en && bus.oDone) done_cnt++;
        end
    end

    function automatic logic [15:0] exp_pix(input logic [15:0] s, input int r);
        int h;
        h = int'(s >> SS);
        if (h > H - 1) h = H - 1;
        return (r > H - 1 - h) ? FG : BG;
    endfunction

    task automatic clear_log;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; proto_err = 0; first_rd = -1; first_wr = -1; last_wr = -1;
        for (int i = 0; i < W*H; i++) gram[i] = 16'hDEAD;
    endtask

    task automatic start_pulse;
        @(negedge clk); bus.iStart = 1;
        @(negedge clk); bus.iStart = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (done_cnt == 0) begin errors++; $display("FAIL %s_timeout: done count %0d, required 1", name, done_cnt); end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_image(input string name);
        for (int c = 0; c < HL; c++)
            for (int r = 0; r < H; r++) begin
                checks++;
                if (gram[r*W+XO+c] !== exp_pix(hist[c], r)) begin
                    errors++;
                    $display("FAIL %s_pix c%0d r%0d: got %h, required %h", name, c, r, gram[r*W+XO+c], exp_pix(hist[c], r));
                end
            end
    endtask

    task automatic check_counts(input string name);
        checks++; if (rd_cnt !== HL) begin errors++; $display("FAIL %s_reads: got %0d, required %0d", name, rd_cnt, HL); end
        checks++; if (wr_cnt !== HL*H) begin errors++; $display("FAIL %s_writes: got %0d, required %0d", name, wr_cnt, HL*H); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: got %0d, required 1", name, done_cnt); end
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL %s_handshake: got %0d violations, required 0", name, proto_err); end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({bus.oBusy, bus.oDone, bus.oSDRAM_Rd_Req, bus.oSDRAM_Wr_Req} !== 4'b0) begin
            errors++; $display("FAIL %s_flags: got %b, required 0000", name, {bus.oBusy, bus.oDone, bus.oSDRAM_Rd_Req, bus.oSDRAM_Wr_Req});
        end
        checks++;
        if ({bus.oSDRAM_Rd_Addr, bus.oSDRAM_Wr_Addr, bus.oSDRAM_Wr_Data} !== 64'b0) begin
            errors++; $display("FAIL %s_buses: rd %h wr %h data %h, required 0", name, bus.oSDRAM_Rd_Addr, bus.oSDRAM_Wr_Addr, bus.oSDRAM_Wr_Data);
        end
    endtask

    task automatic test_reset;
        bus.iStart = 0;
        clear_log();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);
        check_quiet("idle");
    endtask

    task automatic test_basic;
        hist = '{16'd5, 16'd0, 16'd28, 16'd40};
        clear_log(); start_pulse(); wait_done("basic");
        checks++; if (first_rd !== HB) begin errors++; $display("FAIL basic_first_rd: got %0d, required %0d", first_rd, HB); end
        checks++; if (first_wr !== 3) begin errors++; $display("FAIL basic_first_wr: got %0d, required 3", first_wr); end
        checks++; if (last_wr !== 118) begin errors++; $display("FAIL basic_last_wr: got %0d, required 118", last_wr); end
        checks++; if (gram[115] !== FG) begin errors++; $display("FAIL basic_c0_r7: got %h, required %h", gram[115], FG); end
        checks++; if (gram[99] !== BG) begin errors++; $display("FAIL basic_c0_r6: got %h, required %h", gram[99], BG); end
        checks++; if (gram[5] !== BG) begin errors++; $display("FAIL basic_c2_r0: got %h, required %h", gram[5], BG); end
        checks++; if (gram[21] !== FG) begin errors++; $display("FAIL basic_c2_r1: got %h, required %h", gram[21], FG); end
        check_counts("basic"); check_image("basic");
    endtask

    task automatic test_clamp;
        hist = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        clear_log(); start_pulse(); wait_done("clamp");
        for (int c = 0; c < HL; c++) begin
            checks++; if (gram[XO+c] !== BG) begin errors++; $display("FAIL clamp_row0 c%0d: got %h, required %h", c, gram[XO+c], BG); end
            checks++; if (gram[W+XO+c] !== FG) begin errors++; $display("FAIL clamp_row1 c%0d: got %h, required %h", c, gram[W+XO+c], FG); end
        end
        check_counts("clamp"); check_image("clamp");
    endtask

    task automatic test_scale_random;
        hist = '{16'd16, 16'd9, 16'd3, 16'h001F};
        rand_en = 1;
        clear_log(); start_pulse(); wait_done("scale");
        rand_en = 0;
        checks++; if (gram[4*W+XO] !== FG) begin errors++; $display("FAIL scale_c0_r4: got %h, required %h", gram[4*W+XO], FG); end
        checks++; if (gram[3*W+XO] !== BG) begin errors++; $display("FAIL scale_c0_r3: got %h, required %h", gram[3*W+XO], BG); end
        check_counts("scale"); check_image("scale");
    endtask

    task automatic test_start_while_busy;
        int n = 0;
        hist = '{16'd8, 16'd12, 16'd20, 16'd4};
        clear_log(); start_pulse();
        while (rd_cnt < 3 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (rd_cnt < 3) begin errors++; $display("FAIL busy_reach_col2: reads %0d, required 3", rd_cnt); end
        start_pulse(); wait_done("busy");
        check_counts("busy"); check_image("busy");
    endtask

    task automatic test_reset_mid;
        int n = 0;
        hist = '{16'd24, 16'd4, 16'd12, 16'd31};
        clear_log(); start_pulse();
        while (!(bus.oSDRAM_Wr_Req && bus.oSDRAM_Wr_Addr == 24'(5*W+XO+2)) && n < 2000) begin @(negedge clk); n++; end
        checks++; if (n >= 2000) begin errors++; $display("FAIL rstmid_reach: wr addr %0d, required %0d", bus.oSDRAM_Wr_Addr, 5*W+XO+2); end
        rst_n = 0;
        #1 check_quiet("rstmid_async");
        @(posedge clk); #1 check_quiet("rstmid_edge");
        repeat (3) @(negedge clk);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d, required 0", done_cnt); end
        rst_n = 1;
        clear_log(); start_pulse(); wait_done("restart");
        checks++; if (first_rd !== HB) begin errors++; $display("FAIL restart_first_rd: got %0d, required %0d", first_rd, HB); end
        check_counts("restart"); check_image("restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_scale_random();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bar_plot_render.md
BAR_PLOT_RENDER -- requirements
Module: bar_plot_render

Interface
REQ-001 Parameters (name, default, meaning): HIST_BASE, 384000, SDRAM word address of oldest photon-count sample; HIST_LEN, 600, number of samples and plot columns; X_OFS, 100, LCD column of sample 0; LCD_W, 800, GRAM row pitch; LCD_H, 480, plot rows; SCALE_SHIFT, 0, right-shift applied to each count; FG, 16'hFFE0, bar colour; BG, 16'h0000, background colour.
REQ-002 Clock and reset: clk, input, 1, clock; rst_n, input, 1, asynchronous, active-low reset.
REQ-003 Control: en, input, 1, clock enable for the FSM; iStart, input, 1, one-cycle pulse requesting a full redraw; oBusy, output, 1, high while a redraw is in progress; oDone, output, 1, one-cycle pulse when a redraw completes.
REQ-004 SDRAM read: oSDRAM_Rd_Req, output, 1, read request; oSDRAM_Rd_Addr, output, 24, word address; iSDRAM_Data, input, 16, read data; iSDRAM_Rd_Done, input, 1, read-complete strobe.
REQ-005 SDRAM write: oSDRAM_Wr_Req, output, 1, write request; oSDRAM_Wr_Addr, output, 24, word address; oSDRAM_Wr_Data, output, 16, pixel data; iSDRAM_Wr_Done, input, 1, write-complete strobe.

Function
REQ-006 FSM states: IDLE, RD, CALC, WR, NEXT_ROW, NEXT_COL, FIN; all transitions occur only on clk edges where en=1; with en=0 all registers hold.
REQ-007 IDLE: on iStart=1, go to RD with column index c=0 and oBusy=1; iStart is ignored in every other state.
REQ-008 RD: drive oSDRAM_Rd_Addr=HIST_BASE+c and oSDRAM_Rd_Req=1 until iSDRAM_Rd_Done=1 is sampled; on that edge, capture iSDRAM_Data, clear Rd_Req and go to CALC.
REQ-009 CALC: compute h=min(sample>>SCALE_SHIFT, LCD_H-1) as an unsigned 16-bit value, set row r=0, and go to WR (one cycle).
REQ-010 WR: drive oSDRAM_Wr_Addr=r*LCD_W+X_OFS+c (24-bit, no wrap) and oSDRAM_Wr_Data=FG if r>(LCD_H-1-h), else BG, with Wr_Req=1 until iSDRAM_Wr_Done=1 is sampled; on that edge, clear Wr_Req and go to NEXT_ROW.
REQ-011 h=0 draws no FG pixel; h=LCD_H-1 draws FG on rows 1..LCD_H-1, with row 0 always BG.
REQ-012 NEXT_ROW: if r=LCD_H-1 go to NEXT_COL, else r<=r+1 and go to WR.
REQ-013 NEXT_COL: if c=HIST_LEN-1 go to FIN, else c<=c+1 and go to RD.
REQ-014 FIN: pulse oDone for one cycle, drop oBusy and return to IDLE.
REQ-015 Handshake: Addr and Data are stable for the whole time Req is high; Rd_Req and Wr_Req are never high together; a Done strobe arriving while the matching Req is low is ignored.
REQ-016 Pixel addressing is computed by increment (add LCD_W per row), not by a multiplier; the address of the first pixel of each column is X_OFS+c.
REQ-017 One redraw issues exactly HIST_LEN reads and HIST_LEN*LCD_H writes, in column-major order, top row first.

Reset
REQ-018 While rst_n=0: state IDLE; oBusy, oDone, oSDRAM_Rd_Req and oSDRAM_Wr_Req are 0; both addresses, oSDRAM_Wr_Data and internal c, r, h and sample registers are 0.
REQ-019 Reset asserted mid-redraw aborts it immediately with no oDone; the next redraw restarts at c=0.

Verification
REQ-020 Sample[0]=5, SCALE_SHIFT=0, iStart: read addr 384000; column 100 writes rows 0..474 BG and rows 475..479 FG; first write addr 100, last 479*800+100=383300.
REQ-021 Sample=0xFFFF at all columns: h clamps to 479; every column has row 0 BG and rows 1..479 FG; 288000 writes, then oDone pulses once.
REQ-022 SDRAM model with Done delays of 0..7 random cycles and en toggled randomly: Req, Addr and Data are stable until Done; no overlapping Rd/Wr requests; final GRAM image matches the golden model.
REQ-023 iStart pulsed during busy at column 300: ignored; exactly one oDone; read count stays at 600.
REQ-024 rst_n low at column 250 row 17: all outputs 0 next edge and no oDone; a later iStart redraws from read address 384000.
REQ-025 SCALE_SHIFT=4, sample=160: h=10; rows 470..479 FG for that column.
